// File: rtl/mem_pkg.sv
// Shared definitions for the memory-request stage: op bit positions,
// transfer size codes and the request FSM states.
package mem_pkg;

  localparam int LD_LBU = 0;
  localparam int LD_LHU = 1;
  localparam int LD_LW  = 2;
  localparam int LD_LB  = 3;
  localparam int LD_LH  = 4;

  localparam int ST_SB = 0;
  localparam int ST_SH = 1;
  localparam int ST_SW = 2;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/mem_req_stage_if.sv
// Data SRAM-like request/response bus between the memory stage and the interconnect.
interface mem_req_stage_if;
  logic        data_sram_req;
  logic        data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [31:0] data_sram_addr;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_wdata;
  logic        data_sram_addr_ok;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;

  modport master (
    output data_sram_req, data_sram_wr, data_sram_size, data_sram_addr,
           data_sram_wstrb, data_sram_wdata,
    input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
  );

  modport slave (
    input  data_sram_req, data_sram_wr, data_sram_size, data_sram_addr,
           data_sram_wstrb, data_sram_wdata,
    output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
  );
endinterface

// File: rtl/store_align.sv
// Maps a memory op and the low address bits to transfer size, byte strobes,
// lane-replicated store data and a misalignment flag.
module store_align
  import mem_pkg::*;
(
  input  logic [2:0]  store_op,
  input  logic [7:0]  load_op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] st_data,
  output logic [1:0]  size,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic        ale,
  output logic        is_mem
);

  logic is_byte;
  logic is_half;
  logic is_word;

  always_comb begin
    is_byte = store_op[ST_SB] | load_op[LD_LBU] | load_op[LD_LB];
    is_half = store_op[ST_SH] | load_op[LD_LHU] | load_op[LD_LH];
    is_word = store_op[ST_SW] | load_op[LD_LW];
    is_mem  = is_byte | is_half | is_word;

    size = SIZE_BYTE;
    if (is_word)      size = SIZE_WORD;
    else if (is_half) size = SIZE_HALF;

    ale = (is_half & addr_lo[0]) | (is_word & (addr_lo != 2'b00));

    // Loads never write, so their strobes stay zero.
    wstrb = 4'b0000;
    wdata = st_data;
    if (store_op[ST_SB]) begin
      wstrb = 4'b0001 << addr_lo;
      wdata = {4{st_data[7:0]}};
    end else if (store_op[ST_SH]) begin
      wstrb = addr_lo[1] ? 4'b1100 : 4'b0011;
      wdata = {2{st_data[15:0]}};
    end else if (store_op[ST_SW]) begin
      wstrb = 4'b1111;
    end
  end

endmodule

// File: rtl/mem_req_stage.sv
// Memory-access stage: single-entry buffer that issues one data SRAM request per
// load/store, captures raw read data and hands the instruction on to WB.
module mem_req_stage
  import mem_pkg::*;
(
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            ex_pc,
  input  logic [31:0]            ex_result,
  input  logic [31:0]            ex_st_data,
  input  logic [7:0]             ex_load_op,
  input  logic [2:0]             ex_store_op,
  input  logic                   ex_res_from_mem,
  input  logic                   ex_gr_we,
  input  logic [4:0]             ex_dest,
  mem_req_stage_if.master        sram,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_pc,
  output logic [31:0]            out_result,
  output logic [31:0]            out_rdata,
  output logic [7:0]             out_load_op,
  output logic                   out_res_from_mem,
  output logic                   out_gr_we,
  output logic [4:0]             out_dest,
  output logic                   out_ale
);

  state_t      state_q, state_d, acc_state;
  logic        accept;
  logic [1:0]  al_size;
  logic [3:0]  al_wstrb;
  logic [31:0] al_wdata;
  logic        al_ale, al_is_mem;

  logic [31:0] pc_p0, result_p0, rdata_p0, wdata_p0;
  logic [7:0]  load_op_p0;
  logic        res_from_mem_p0, gr_we_p0, ale_p0, wr_p0, is_load_p0;
  logic [4:0]  dest_p0;
  logic [1:0]  size_p0;
  logic [3:0]  wstrb_p0;

  store_align u_align (
    .store_op (ex_store_op),
    .load_op  (ex_load_op),
    .addr_lo  (ex_result[1:0]),
    .st_data  (ex_st_data),
    .size     (al_size),
    .wstrb    (al_wstrb),
    .wdata    (al_wdata),
    .ale      (al_ale),
    .is_mem   (al_is_mem)
  );

  assign in_ready  = (state_q == S_IDLE) | ((state_q == S_DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign acc_state = (al_is_mem & ~al_ale) ? S_REQ : S_DONE;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d            = state_q;
    sram.data_sram_req = 1'b0;
    out_valid          = 1'b0;
    unique case (state_q)
      S_IDLE: if (in_valid) state_d = acc_state;
      S_REQ: begin
        sram.data_sram_req = 1'b1;
        if (sram.data_sram_addr_ok) state_d = S_RESP;
      end
      // A data_ok while still in REQ is illegal and deliberately not observed.
      S_RESP: if (sram.data_sram_data_ok) state_d = S_DONE;
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = in_valid ? acc_state : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---- stage p0: instruction buffer, loaded on accept ----
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc_p0           <= '0;
      result_p0       <= '0;
      rdata_p0        <= '0;
      wdata_p0        <= '0;
      load_op_p0      <= '0;
      res_from_mem_p0 <= 1'b0;
      gr_we_p0        <= 1'b0;
      ale_p0          <= 1'b0;
      wr_p0           <= 1'b0;
      is_load_p0      <= 1'b0;
      dest_p0         <= '0;
      size_p0         <= '0;
      wstrb_p0        <= '0;
    end else if (accept) begin
      pc_p0           <= ex_pc;
      result_p0       <= ex_result;
      rdata_p0        <= '0;
      wdata_p0        <= al_wdata;
      load_op_p0      <= ex_load_op;
      res_from_mem_p0 <= ex_res_from_mem;
      gr_we_p0        <= ex_gr_we & ~al_ale;
      ale_p0          <= al_ale;
      wr_p0           <= |ex_store_op;
      is_load_p0      <= |ex_load_op;
      dest_p0         <= ex_dest;
      size_p0         <= al_size;
      wstrb_p0        <= al_wstrb;
    end else if ((state_q == S_RESP) && sram.data_sram_data_ok && is_load_p0) begin
      rdata_p0 <= sram.data_sram_rdata;
    end
  end

  assign sram.data_sram_wr    = wr_p0;
  assign sram.data_sram_size  = size_p0;
  assign sram.data_sram_addr  = result_p0;
  assign sram.data_sram_wstrb = wstrb_p0;
  assign sram.data_sram_wdata = wdata_p0;

  assign out_pc           = pc_p0;
  assign out_result       = result_p0;
  assign out_rdata        = rdata_p0;
  assign out_load_op      = load_op_p0;
  assign out_res_from_mem = res_from_mem_p0;
  assign out_gr_we        = gr_we_p0;
  assign out_dest         = dest_p0;
  assign out_ale          = ale_p0;

endmodule

// File: tb/tb_mem_req_stage.sv
// Bench for mem_req_stage: queue-based reference model, configurable SRAM
// responder and directed load/store/ALU sequences with literal expectations.
module tb_mem_req_stage;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] ex_pc, ex_result, ex_st_data;
  logic [7:0]  ex_load_op;
  logic [2:0]  ex_store_op;
  logic        ex_res_from_mem, ex_gr_we;
  logic [4:0]  ex_dest;
  logic        out_valid, out_ready;
  logic [31:0] out_pc, out_result, out_rdata;
  logic [7:0]  out_load_op;
  logic        out_res_from_mem, out_gr_we, out_ale;
  logic [4:0]  out_dest;

  mem_req_stage_if sram();

  mem_req_stage dut (
    .clk              (clk),
    .resetn           (resetn),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .ex_pc            (ex_pc),
    .ex_result        (ex_result),
    .ex_st_data       (ex_st_data),
    .ex_load_op       (ex_load_op),
    .ex_store_op      (ex_store_op),
    .ex_res_from_mem  (ex_res_from_mem),
    .ex_gr_we         (ex_gr_we),
    .ex_dest          (ex_dest),
    .sram             (sram),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_pc           (out_pc),
    .out_result       (out_result),
    .out_rdata        (out_rdata),
    .out_load_op      (out_load_op),
    .out_res_from_mem (out_res_from_mem),
    .out_gr_we        (out_gr_we),
    .out_dest         (out_dest),
    .out_ale          (out_ale)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] pc, result, rdata, wdata;
    logic [7:0]  ld;
    logic        rfm, we, ale, mem, wr;
    logic [4:0]  dest;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    int          acc_cyc, reqc;
    bit          seen, addr_done;
  } rec_t;

  rec_t q[$];

  function automatic rec_t model(input logic [31:0] pc, res, sd, input logic [7:0] ld,
                                 input logic [2:0] st, input logic rfm, we,
                                 input logic [4:0] dest, input logic [31:0] rd);
    rec_t r;
    int nb;
    nb = (ld[0] | ld[3] | st[0]) ? 1 : (ld[1] | ld[4] | st[1]) ? 2 : (ld[2] | st[2]) ? 4 : 0;
    r.pc = pc; r.result = res; r.ld = ld; r.rfm = rfm; r.dest = dest;
    r.mem   = (nb != 0);
    r.ale   = r.mem && ((int'(res[1:0]) % nb) != 0);
    r.size  = (nb == 4) ? 2'd2 : (nb == 2) ? 2'd1 : 2'd0;
    r.wr    = (st != 3'b000);
    r.we    = we & ~r.ale;
    r.wstrb = r.wr ? 4'(((1 << nb) - 1) << res[1:0]) : 4'b0000;
    r.wdata = '0;
    if (r.wr)
      for (int i = 0; i < 4; i++) r.wdata[8*i +: 8] = sd[8*(i % nb) +: 8];
    r.rdata = ((ld != 8'd0) && !r.ale) ? rd : 32'd0;
    r.acc_cyc = 0; r.reqc = 0; r.seen = 0; r.addr_done = 0;
    return r;
  endfunction

  // ---------------- SRAM responder ----------------
  int          addr_ok_dly = 0;
  int          data_ok_dly = 0;
  logic [31:0] resp_rdata  = '0;
  int          stray_cnt   = 0;

  initial begin : responder
    int a_cnt, d_cnt, stray_done;
    bit pend;
    a_cnt = 0; d_cnt = 0; stray_done = 0; pend = 0;
    sram.data_sram_addr_ok = 1'b0;
    sram.data_sram_data_ok = 1'b0;
    sram.data_sram_rdata   = '0;
    forever begin
      @(posedge clk); #1;
      sram.data_sram_addr_ok = 1'b0;
      sram.data_sram_data_ok = 1'b0;
      if (!resetn) begin
        pend = 0; a_cnt = 0;
      end else begin
        if (pend) begin
          if (d_cnt == 0) begin
            sram.data_sram_data_ok = 1'b1; sram.data_sram_rdata = resp_rdata; pend = 0;
          end else d_cnt--;
        end
        if (stray_cnt != stray_done) begin
          sram.data_sram_data_ok = 1'b1; sram.data_sram_rdata = 32'h55AA55AA; stray_done++;
        end
        if (sram.data_sram_req) begin
          if (a_cnt == addr_ok_dly) begin
            sram.data_sram_addr_ok = 1'b1; a_cnt = 0; pend = 1; d_cnt = data_ok_dly;
          end else a_cnt++;
        end
      end
    end
  end

  // ---------------- per-cycle compare against the model ----------------
  int          retire_cnt = 0, last_lat = 0, last_reqc = 0, last_retire_cyc = 0;
  logic [31:0] last_rdata = '0, first_wdata = '0;
  logic        last_ale = 0, last_gr_we = 0;
  logic [3:0]  first_wstrb = '0;
  logic [1:0]  first_size = '0;

  always @(negedge clk) begin
    if (!resetn) q.delete();
    else begin
      chk("in_ready", in_ready, (q.size() == 0) || (out_valid && out_ready));
      if (sram.data_sram_req) begin
        chk("req_has_txn", q.size() != 0, 1);
        if (q.size() != 0) begin
          chk("req_expected", q[0].mem && !q[0].ale && !q[0].addr_done, 1);
          chk("req_wr", sram.data_sram_wr, q[0].wr);
          chk("req_size", sram.data_sram_size, q[0].size);
          chk("req_addr", sram.data_sram_addr, q[0].result);
          chk("req_wstrb", sram.data_sram_wstrb, q[0].wstrb);
          if (q[0].wr) chk("req_wdata", sram.data_sram_wdata, q[0].wdata);
          if (q[0].reqc == 0) begin
            first_wstrb = sram.data_sram_wstrb;
            first_wdata = sram.data_sram_wdata;
            first_size  = sram.data_sram_size;
          end
          q[0].reqc++;
          if (sram.data_sram_addr_ok) q[0].addr_done = 1;
        end
      end
      if (out_valid) begin
        chk("out_has_txn", q.size() != 0, 1);
        if (q.size() != 0) begin
          chk("out_pc", out_pc, q[0].pc);
          chk("out_result", out_result, q[0].result);
          chk("out_rdata", out_rdata, q[0].rdata);
          chk("out_load_op", out_load_op, q[0].ld);
          chk("out_res_from_mem", out_res_from_mem, q[0].rfm);
          chk("out_gr_we", out_gr_we, q[0].we);
          chk("out_dest", out_dest, q[0].dest);
          chk("out_ale", out_ale, q[0].ale);
          if (!q[0].seen) begin
            q[0].seen = 1;
            last_lat  = cyc - q[0].acc_cyc;
          end
          if (out_ready) begin
            last_reqc = q[0].reqc; last_rdata = out_rdata; last_ale = out_ale;
            last_gr_we = out_gr_we; last_retire_cyc = cyc;
            retire_cnt++;
            void'(q.pop_front());
          end
        end
      end
      if (in_valid && in_ready) begin
        rec_t r;
        r = model(ex_pc, ex_result, ex_st_data, ex_load_op, ex_store_op,
                  ex_res_from_mem, ex_gr_we, ex_dest, resp_rdata);
        r.acc_cyc = cyc;
        q.push_back(r);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_ex(input logic [31:0] pc, res, sd, input logic [7:0] ld,
                        input logic [2:0] st, input logic rfm, we, input logic [4:0] dest);
    ex_pc = pc; ex_result = res; ex_st_data = sd; ex_load_op = ld;
    ex_store_op = st; ex_res_from_mem = rfm; ex_gr_we = we; ex_dest = dest;
  endtask

  task automatic issue(input logic [31:0] pc, res, sd, input logic [7:0] ld,
                       input logic [2:0] st, input logic rfm, we, input logic [4:0] dest);
    bit got;
    set_ex(pc, res, sd, ld, st, rfm, we, dest);
    in_valid = 1'b1;
    got = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (in_ready) begin got = 1; break; end
    end
    chk("accept", got, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_retire(input int target);
    for (int i = 0; i < 60 && retire_cnt < target; i++) @(posedge clk);
    #1;
    chk("retire", retire_cnt >= target, 1);
  endtask

  task automatic run_op(input logic [31:0] pc, res, sd, input logic [7:0] ld,
                        input logic [2:0] st, input logic rfm, we, input logic [4:0] dest);
    int t;
    t = retire_cnt + 1;
    issue(pc, res, sd, ld, st, rfm, we, dest);
    wait_retire(t);
  endtask

  task automatic set_add(input int idx);
    set_ex(32'h200 + 32'(4 * idx), 32'h1000 + 32'(17 * idx), 32'd0, 8'd0, 3'd0,
           1'b0, 1'b1, 5'(idx + 1));
  endtask

  task automatic feed(input int n, input bit toggle);
    int idx, start, fa;
    bit acc;
    idx = 0; start = retire_cnt; fa = -1;
    set_add(0);
    in_valid = 1'b1;
    for (int c = 0; c < 40 && idx < n; c++) begin
      out_ready = toggle ? (c % 2 == 0) : 1'b1;
      @(negedge clk);
      acc = in_valid && in_ready;
      if (acc && fa < 0) fa = cyc;
      @(posedge clk); #1;
      if (acc) begin
        idx++;
        if (idx < n) set_add(idx);
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    for (int c = 0; c < 40 && retire_cnt < start + n; c++) begin
      out_ready = toggle ? (c % 2 == 0) : 1'b1;
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    chk("feed_count", retire_cnt - start, n);
    if (!toggle) chk("feed_throughput", last_retire_cyc - fa, n);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int rc;
    bit got;
    resetn = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    set_ex(32'hFFFF_FFFC, 32'h0, 32'h0, 8'd0, 3'd0, 1'b0, 1'b1, 5'd3);
    repeat (3) begin
      @(negedge clk);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_req", sram.data_sram_req, 0);
      chk("rst_out_valid", out_valid, 0);
    end
    @(posedge clk); #1;
    resetn = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_out_ale", out_ale, 0);
    chk("post_rst_out_valid", out_valid, 0);

    // SB at 0x1003, immediate handshakes
    @(posedge clk); #1;
    addr_ok_dly = 0; data_ok_dly = 0;
    run_op(32'h100, 32'h1003, 32'h12345678, 8'd0, 3'b001, 1'b0, 1'b0, 5'd0);
    chk("sb_wstrb", first_wstrb, 4'b1000);
    chk("sb_wdata", first_wdata, 32'h78787878);
    chk("sb_size", first_size, 2'd0);
    chk("sb_latency", last_lat, 3);
    chk("sb_req_cycles", last_reqc, 1);

    // LW at 0x2000, addr_ok after 2 wait cycles, data_ok 3 cycles after that
    addr_ok_dly = 2; data_ok_dly = 2; resp_rdata = 32'hDEADBEEF;
    run_op(32'h104, 32'h2000, 32'h0, 8'b0000_0100, 3'd0, 1'b1, 1'b1, 5'd5);
    chk("lw_req_cycles", last_reqc, 3);
    chk("lw_rdata", last_rdata, 32'hDEADBEEF);
    chk("lw_latency", last_lat, 7);

    // Misaligned SH at 0x1001
    addr_ok_dly = 0; data_ok_dly = 0;
    run_op(32'h108, 32'h1001, 32'h0000ABCD, 8'd0, 3'b010, 1'b0, 1'b1, 5'd7);
    chk("sh_ale", last_ale, 1);
    chk("sh_gr_we", last_gr_we, 0);
    chk("sh_latency", last_lat, 1);
    chk("sh_req_cycles", last_reqc, 0);

    // Back-to-back ALU ops, free-flowing then with out_ready toggling
    feed(3, 1'b0);
    feed(3, 1'b1);

    // Further stores and loads
    run_op(32'h110, 32'h3006, 32'h00001234, 8'd0, 3'b010, 1'b0, 1'b0, 5'd0);
    chk("sh_hi_wstrb", first_wstrb, 4'b1100);
    chk("sh_hi_wdata", first_wdata, 32'h12341234);
    addr_ok_dly = 1; data_ok_dly = 0;
    run_op(32'h114, 32'h3004, 32'hCAFEF00D, 8'd0, 3'b100, 1'b0, 1'b0, 5'd0);
    resp_rdata = 32'h8001ABCD; data_ok_dly = 1;
    run_op(32'h118, 32'h2002, 32'h0, 8'b0001_0000, 3'd0, 1'b1, 1'b1, 5'd9);
    resp_rdata = 32'h11223344; addr_ok_dly = 0; data_ok_dly = 0;
    run_op(32'h11C, 32'h2003, 32'h0, 8'b0000_0001, 3'd0, 1'b1, 1'b1, 5'd10);
    run_op(32'h120, 32'h2002, 32'h0, 8'b0000_0100, 3'd0, 1'b1, 1'b1, 5'd11);
    chk("lw_mis_ale", last_ale, 1);
    chk("lw_mis_rdata", last_rdata, 0);

    // Reset while waiting for the read response
    addr_ok_dly = 0; data_ok_dly = 10; resp_rdata = 32'h0BAD0BAD;
    rc = retire_cnt;
    issue(32'h124, 32'h2010, 32'h0, 8'b0000_0100, 3'd0, 1'b1, 1'b1, 5'd12);
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sram.data_sram_req && sram.data_sram_addr_ok) begin got = 1; break; end
    end
    chk("resp_reached", got, 1);
    @(posedge clk); #2;
    resetn = 1'b0;
    #1;
    chk("arst_req", sram.data_sram_req, 0);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    stray_cnt++;
    repeat (4) begin
      @(negedge clk);
      chk("stray_out_valid", out_valid, 0);
      chk("stray_in_ready", in_ready, 1);
    end
    chk("stray_retire", retire_cnt, rc);

    // Recovery after reset
    @(posedge clk); #1;
    data_ok_dly = 0; resp_rdata = 32'h99887766;
    run_op(32'h128, 32'h2001, 32'h0, 8'b0000_0001, 3'd0, 1'b1, 1'b1, 5'd13);
    chk("recover_rdata", last_rdata, 32'h99887766);
    chk("recover_latency", last_lat, 3);

    repeat (2) @(posedge clk);
    chk("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule

// File: doc/mem_req_stage.md
# mem_req_stage

Memory-access pipeline stage, the initiator side of the data SRAM-like interface. It accepts one instruction at a time from EX and, for loads and stores, issues a single request with byte-lane strobes and lane-replicated store data. It waits for the address and data handshakes, captures raw read data and hands the instruction to WB over a valid/ready handshake. WB does the load byte selection and extension; this block does none.

## Interface
- Parameters: none. Data and address widths are fixed at 32.
- `clk` in 1: sole clock, rising edge.
- `resetn` in 1: asynchronous assert, active-low reset.
- `in_valid` in 1: EX holds an instruction.
- `in_ready` out 1: stage accepts this cycle.
- `ex_pc` in 32: instruction PC.
- `ex_result` in 32: ALU result, which is the effective address for memory ops.
- `ex_st_data` in 32: store source register value.
- `ex_load_op` in 8: bit 0 LBU, 1 LHU, 2 LW, 3 LB, 4 LH; bits 7:5 are zero.
- `ex_store_op` in 3: bit 0 SB, 1 SH, 2 SW.
- `ex_res_from_mem` in 1: result comes from memory.
- `ex_gr_we` in 1: register write enable.
- `ex_dest` in 5: destination register.
- `data_sram_req` out 1: request valid.
- `data_sram_wr` out 1: 1 for a store.
- `data_sram_size` out 2: 0 byte, 1 half, 2 word.
- `data_sram_addr` out 32: full byte address.
- `data_sram_wstrb` out 4: byte strobes; 0 for loads.
- `data_sram_wdata` out 32: lane-replicated store data.
- `data_sram_addr_ok` in 1: request accepted this cycle.
- `data_sram_data_ok` in 1: response this cycle.
- `data_sram_rdata` in 32: read data, valid with `data_ok`.
- `out_valid` out 1: WB-bound instruction valid.
- `out_ready` in 1: WB accepts.
- `out_pc`, `out_result`, `out_rdata` out 32: registered PC, result and captured read data.
- `out_load_op` out 8, `out_res_from_mem` out 1, `out_dest` out 5: registered copies.
- `out_gr_we` out 1: registered copy, forced to 0 when `out_ale` is set.
- `out_ale` out 1: misaligned access; the access is not issued.

## Operation
- Single-entry buffer with a four-state FSM: IDLE, REQ, RESP, DONE.
- `in_ready` = (state==IDLE) | (state==DONE & out_ready).
- On accept, all `ex_*` fields are registered. The next state depends on the accepted instruction:
  - REQ if any load_op/store_op bit is set and the address is aligned.
  - Otherwise DONE.
- Alignment rule: half accesses need addr[0]=0; word accesses need addr[1:0]=0.
- A misaligned access goes straight to DONE with `out_ale`=1 and `out_gr_we`=0, and no request is issued.
- REQ:
  - `data_sram_req`=1, with all request fields driven from registers and held stable until `addr_ok`.
  - `addr_ok` moves the FSM to RESP.
  - `data_ok` seen in REQ is ignored, because the protocol forbids it.
- RESP: `req`=0. On `data_ok`, latch `rdata` into `out_rdata` (loads only; stores keep 0) and move to DONE.
- DONE: `out_valid`=1. On `out_ready` the FSM goes to IDLE, or takes the newly accepted instruction's next state in the same cycle.
- Strobes:
  - SB: 4'b0001 << addr[1:0].
  - SH: addr[1] ? 4'b1100 : 4'b0011.
  - SW: 4'b1111.
- Store data:
  - SB: {4{st_data[7:0]}}.
  - SH: {2{st_data[15:0]}}.
  - SW: st_data.
- Loads use the same size coding with wstrb=0 and wr=0.

## Timing
- Reset: state IDLE. Every output register is 0, so `out_valid`, `data_sram_req` and `out_ale` are 0 and `in_ready`=1 on the first cycle after release.
- Non-memory op accepted at cycle N: `out_valid` at N+1.
- Memory op accepted at N:
  - `req` at N+1.
  - With `addr_ok` at N+1 and `data_ok` at N+2, `out_valid` is at N+3. This is the minimum latency.
- Wait states on `addr_ok` or `data_ok` extend the latency one cycle each.
- Back-pressure: DONE with `out_ready`=0 holds every `out_*` stable and keeps `in_ready`=0.
- Simultaneous DONE&out_ready and in_valid: retire and accept in the same cycle with no bubble. Throughput is one non-memory op per cycle.
- Reset asserted mid-transaction: immediate return to IDLE and `req` drops asynchronously. The interconnect is reset by the same `resetn`, so no response is awaited.

## Structure
- Shared package `mem_pkg`:
  - load_op and store_op bit indices.
  - Size codes.
  - FSM state enum.
- Sub-module `store_align`: combinational map from (store_op, load_op, addr[1:0], st_data) to size, wstrb, wdata and ale.

## Test plan
- Reset: with resetn low, force `in_valid`=1 → `in_ready`=1 after release; `req`=0 and `out_valid`=0 throughout reset.
- SB at addr 0x1003, data 0x12345678, with addr_ok and data_ok immediate → `wstrb`=4'b1000, `wdata`=0x78787878, size 0, `out_valid` 3 cycles after accept.
- LW at 0x2000 with addr_ok delayed 2 cycles and data_ok 3 cycles later, rdata 0xDEADBEEF → `req` held 3 cycles with stable fields; `out_rdata`=0xDEADBEEF.
- SH at 0x1001 → no `req`; `out_ale`=1 and `out_gr_we`=0 one cycle after accept.
- Back-to-back ADDs with `out_ready` toggling 1,0,1 → one retire per ready cycle, fields held while stalled, no drops or duplicates.
- Reset asserted in RESP → `req` is 0 and the FSM is in IDLE immediately; a later data_ok is ignored.
